hazard_detection_unit: RTL and testbench

- Companion to the pipeline's forwarding logic. Forwarding bypasses results forward to consumers; this block keeps producers and consumers apart in time by stalling and flushing the pipeline.
- Keeps a shadow scoreboard of destination registers in flight in the EX, MEM and WB stages.
- Drives PC/IF-ID write-enables, ID/EX bubble insertion and branch flushes for the 5-stage MIPS pipeline.
- Maintains a saturating stall-cycle counter for performance reporting.

---
 rtl/hazard_detection_unit.sv | 116 +++++++++++
 tb/tb_hazard_detection_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
// Stall/flush control for a 5-stage MIPS pipeline. A shadow scoreboard tracks
// the destination registers held in the EX, MEM and WB stages. The unit drives
// the PC and IF/ID write enables, inserts ID/EX bubbles and flushes IF/ID on
// taken branches. It also keeps a saturating count of stall cycles.
// Optional build macro HAZARD_NOFWD_EN targets a pipeline without forwarding.
// In that build any EX or MEM producer stalls its consumer; the default build
// stalls only on load-use.
module hazard_detection_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_regs_i,
  input  logic [4:0]       id_regt_i,
  input  logic             id_uses_rt_i,
  input  logic [4:0]       id_regd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } sb_entry_t;

  // WB never sources a hazard, because the register file writes before it
  // reads. The entry is still tracked so that the pipeline view stays complete.
  localparam logic WB_SRC_EN = 1'b0;

  sb_entry_t        ex_q, ex_d, mem_q, wb_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             flush;
  logic             stall;

  // An entry is a live, non-$0 writer whose rd matches a source read in ID.
  function automatic logic src_match(input sb_entry_t e, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return e.v && e.rw && (e.rd != 5'd0) &&
           ((e.rd == rs) || (uses_rt && (e.rd == rt)));
  endfunction

  // Combinational hazard detection for the instruction currently in ID.
  always_comb begin
    hazard = 1'b0;
`ifdef HAZARD_NOFWD_EN
    hazard = id_valid_i &&
             (src_match(ex_q, id_regs_i, id_regt_i, id_uses_rt_i) ||
              src_match(mem_q, id_regs_i, id_regt_i, id_uses_rt_i) ||
              (WB_SRC_EN && src_match(wb_q, id_regs_i, id_regt_i, id_uses_rt_i)));
`else
    hazard = id_valid_i &&
             ((ex_q.ld && src_match(ex_q, id_regs_i, id_regt_i, id_uses_rt_i)) ||
              (WB_SRC_EN && src_match(wb_q, id_regs_i, id_regt_i, id_uses_rt_i)));
`endif
  end

  // Flush beats stall. Under reset both are forced inactive.
  assign flush = branch_taken_i && rst_i;
  assign stall = hazard && !flush && rst_i;

  assign pc_write_o    = !stall;
  assign ifid_write_o  = !stall;
  assign ifid_flush_o  = flush;
  assign idex_bubble_o = stall || flush;
  assign stall_cnt_o   = cnt_q;

  // Next EX entry: a bubble on stall/flush, otherwise the ID instruction.
  always_comb begin
    ex_d = '0;
    if (stall || flush) begin
      ex_d = '0;
    end else begin
      ex_d.v  = id_valid_i;
      ex_d.rd = id_regd_i;
      ex_d.rw = id_regwrite_i && id_valid_i;
      ex_d.ld = id_memread_i && id_valid_i;
    end
  end

  // Saturating stall counter next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Scoreboard shift and counter update. Async reset clears everything at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit. The stimulus process applies
// inputs and pushes expected outputs, which come from a reference model of
// in-flight instructions. A monitor process pops and compares on the falling
// edge. Two instances run in parallel: one uses the default 16-bit counter and
// one uses a 4-bit counter, so that counter saturation is visible.
module tb_hazard_detection_unit;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_regs_i = 5'd0;
  logic [4:0] id_regt_i = 5'd0;
  logic       id_uses_rt_i = 1'b0;
  logic [4:0] id_regd_i = 5'd0;
  logic       id_regwrite_i = 1'b0;
  logic       id_memread_i = 1'b0;
  logic       branch_taken_i = 1'b0;

  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic [15:0] stall_cnt_o;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
  logic [3:0]  s_stall_cnt;

  always #5 clk_i = ~clk_i;

  hazard_detection_unit #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_regs_i(id_regs_i), .id_regt_i(id_regt_i), .id_uses_rt_i(id_uses_rt_i),
    .id_regd_i(id_regd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .stall_cnt_o(stall_cnt_o)
  );

  hazard_detection_unit #(.CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_regs_i(id_regs_i), .id_regt_i(id_regt_i), .id_uses_rt_i(id_uses_rt_i),
    .id_regd_i(id_regd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .branch_taken_i(branch_taken_i),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
    .ifid_flush_o(s_ifid_flush), .idex_bubble_o(s_idex_bubble),
    .stall_cnt_o(s_stall_cnt)
  );

  // An instruction that has left ID, or a bubble (all zeros).
  typedef struct {
    logic       writes;
    logic       load;
    logic [4:0] rd;
  } instr_t;

  typedef struct {
    logic pcw;
    logic flush;
    logic bubble;
    int   cnt16;
    int   cnt4;
  } exp_t;

  instr_t hist[$];      // hist[0] is the most recently issued (now in EX)
  exp_t   sbq[$];
  int     total_stalls = 0;
  logic   exp_stall = 1'b0;
  logic   exp_flush = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     stall_seen = 0;

  function automatic int sat(input int t, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (t > mx) ? mx : t;
  endfunction

  function automatic logic reads_reg(input logic [4:0] r);
    return (r != 5'd0) && ((r == id_regs_i) || (id_uses_rt_i && (r == id_regt_i)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The clock edge retires the current ID decision into the model.
  task automatic advance_model();
    instr_t n;
    if (rst_i) begin
      if (exp_stall) total_stalls++;
      n.writes = 1'b0; n.load = 1'b0; n.rd = 5'd0;
      if (!(exp_stall || exp_flush)) begin
        n.writes = id_valid_i && id_regwrite_i;
        n.load   = id_valid_i && id_memread_i;
        n.rd     = id_regd_i;
      end
      hist.push_front(n);
      if (hist.size() > 3) void'(hist.pop_back());
    end
  endtask

  // Compute the expected outputs for the inputs now applied and queue them.
  task automatic compute_expect();
    exp_t e;
    logic hz;
    hz = 1'b0;
    if (!rst_i) begin
      hist.delete();
      total_stalls = 0;
      exp_stall = 1'b0;
      exp_flush = 1'b0;
    end else begin
`ifdef HAZARD_NOFWD_EN
      // Without forwarding, any writer in the next two stages blocks a reader.
      for (int k = 0; k < 2 && k < hist.size(); k++)
        if (hist[k].writes && reads_reg(hist[k].rd)) hz = 1'b1;
`else
      // With forwarding, only a load directly ahead is a hazard.
      if (hist.size() > 0)
        if (hist[0].load && hist[0].writes && reads_reg(hist[0].rd)) hz = 1'b1;
`endif
      hz = hz && id_valid_i;
      exp_flush = branch_taken_i;
      exp_stall = hz && !exp_flush;
    end
    e.pcw    = !exp_stall;
    e.flush  = exp_flush;
    e.bubble = exp_stall || exp_flush;
    e.cnt16  = sat(total_stalls, 16);
    e.cnt4   = sat(total_stalls, 4);
    if (exp_stall) stall_seen++;
    sbq.push_back(e);
  endtask

  task automatic step(input logic rst, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic br);
    @(posedge clk_i);
    advance_model();
    #1;
    rst_i = rst; id_valid_i = v; id_regs_i = rs; id_regt_i = rt;
    id_uses_rt_i = urt; id_regd_i = rd; id_regwrite_i = rw;
    id_memread_i = ld; branch_taken_i = br;
    compute_expect();
  endtask

  task automatic nop();
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] rreg();
    logic [4:0] t [4];
    t[0] = 5'd0; t[1] = 5'd8; t[2] = 5'd9; t[3] = 5'd10;
    return t[$urandom_range(0, 3)];
  endfunction

  // Monitor: compare the DUT outputs against the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("pc_write",    {31'd0, pc_write_o},    {31'd0, e.pcw});
      check("ifid_write",  {31'd0, ifid_write_o},  {31'd0, e.pcw});
      check("ifid_flush",  {31'd0, ifid_flush_o},  {31'd0, e.flush});
      check("idex_bubble", {31'd0, idex_bubble_o}, {31'd0, e.bubble});
      check("stall_cnt16", {16'd0, stall_cnt_o},   e.cnt16);
      check("sat_bubble",  {31'd0, s_idex_bubble}, {31'd0, e.bubble});
      check("sat_pc_write",{31'd0, s_pc_write},    {31'd0, e.pcw});
      check("stall_cnt4",  {28'd0, s_stall_cnt},   e.cnt4);
    end
  end

  initial begin
    // Reset, held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'($urandom), rreg(), rreg(), 1'($urandom), rreg(),
           1'($urandom), 1'($urandom), 1'($urandom));
    nop();
    // Load-use: lw $8 ; add $9,$8,$10 (held through its one stall cycle).
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    nop(); nop();
    // lw $0 ; add reading $0: no stall.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    nop();
    // lw $8 ; addi with rt=8 but rt not read: no stall.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    // Load-use plus a taken branch in the same cycle: the flush wins.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    nop();
    // 20 load-use stalls, which saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 5'd10, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    end
    nop(); nop();
    // ALU producer: add $8 ; sub $9,$8,$8 (held while stalled).
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    nop(); nop();
    // Same, with one independent instruction in between.
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    nop(); nop();
    // Asynchronous reset while a load-use hazard is pending.
    step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd8, 5'd10, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    // Randomized traffic over a small register set, so that hazards are frequent.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) != 0), rreg(), rreg(),
           1'($urandom), rreg(), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 9) == 0));
    nop();
    // Drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk_i);
    #1;
    check("scoreboard_drained", sbq.size(), 32'd0);
    check("stalls_exercised", {31'd0, (stall_seen > 20)}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
